// File: rtl/ladybird_pkg.sv
// Shared types and constants for the ladybird stream FIFO family.
// The FIFO operation for a cycle is encoded as {write, read}.
package ladybird_pkg;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_R    = 2'b01,
        FIFO_W    = 2'b10,
        FIFO_WR   = 2'b11
    } fifo_op_t;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/ladybird_fifo_ctrl.sv
// Bookkeeping for the level FIFO: pointers, occupancy, full, level flags and the
// saturating drop counter. All outputs come straight from registers.
module ladybird_fifo_ctrl
    import ladybird_pkg::*;
#(
    parameter int FIFO_DEPTH_W = 5,
    parameter int AF_LEVEL     = 28,
    parameter int AE_LEVEL     = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  fifo_op_t                op,
    input  logic                    flush,
    input  logic                    drop_req,
    output logic [FIFO_DEPTH_W-1:0] wr_ptr,
    output logic [FIFO_DEPTH_W-1:0] rd_ptr,
    output logic [FIFO_DEPTH_W:0]   count,
    output logic                    full,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    localparam int CW = FIFO_DEPTH_W + 1;
    localparam logic [CW-1:0]           DEPTH_C  = CW'(1 << FIFO_DEPTH_W);
    localparam logic [CW-1:0]           AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0]           AE_C     = CW'(AE_LEVEL);
    localparam logic [CW-1:0]           CNT_ONE  = CW'(1);
    localparam logic [FIFO_DEPTH_W-1:0] PTR_ONE  = FIFO_DEPTH_W'(1);
    localparam logic [DROP_CNT_W-1:0]   DROP_ONE = DROP_CNT_W'(1);

    logic [FIFO_DEPTH_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [FIFO_DEPTH_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]           count_reg, count_next;
    logic                    full_reg, full_next;
    logic                    almost_full_reg, almost_full_next;
    logic                    almost_empty_reg, almost_empty_next;
    logic [DROP_CNT_W-1:0]   drop_cnt_reg, drop_cnt_next;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        drop_cnt_next = drop_cnt_reg;

        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            case (op)
                FIFO_W: begin
                    wr_ptr_next = wr_ptr_reg + PTR_ONE;
                    count_next  = count_reg + CNT_ONE;
                end
                FIFO_R: begin
                    rd_ptr_next = rd_ptr_reg + PTR_ONE;
                    count_next  = count_reg - CNT_ONE;
                end
                FIFO_WR: begin
                    wr_ptr_next = wr_ptr_reg + PTR_ONE;
                    rd_ptr_next = rd_ptr_reg + PTR_ONE;
                end
                default: begin
                end
            endcase
            if (drop_req && (drop_cnt_reg != '1)) begin
                drop_cnt_next = drop_cnt_reg + DROP_ONE;
            end
        end

        // Flags are taken from the next count so they change on the same edge as count.
        full_next         = (count_next == DEPTH_C);
        almost_full_next  = (count_next >= AF_C);
        almost_empty_next = (count_next <= AE_C);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            full_reg         <= 1'b0;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            drop_cnt_reg     <= '0;
        end else begin
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            count_reg        <= count_next;
            full_reg         <= full_next;
            almost_full_reg  <= almost_full_next;
            almost_empty_reg <= almost_empty_next;
            drop_cnt_reg     <= drop_cnt_next;
        end
    end

    assign wr_ptr       = wr_ptr_reg;
    assign rd_ptr       = rd_ptr_reg;
    assign count        = count_reg;
    assign full         = full_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign drop_cnt     = drop_cnt_reg;

endmodule

// File: rtl/ladybird_level_fifo.sv
// First-word-fall-through valid/ready FIFO with occupancy, level flags, flush and
// an optional drop-counting mode. Holds the storage array and the handshake logic.
module ladybird_level_fifo
    import ladybird_pkg::*;
#(
    parameter int FIFO_DEPTH_W = 5,
    parameter int DATA_W       = 8,
    parameter int AF_LEVEL     = 28,
    parameter int AE_LEVEL     = 4,
    parameter int DROP_MODE    = 0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [DATA_W-1:0]     a_data,
    input  logic                  a_valid,
    output logic                  a_ready,
    output logic [DATA_W-1:0]     b_data,
    output logic                  b_valid,
    input  logic                  b_ready,
    input  logic                  flush,
    output logic [FIFO_DEPTH_W:0] count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int DEPTH = 1 << FIFO_DEPTH_W;

    if (FIFO_DEPTH_W < 1 || FIFO_DEPTH_W > 12) begin : g_bad_depth
        $error("ladybird_level_fifo: FIFO_DEPTH_W=%0d outside 1..12", FIFO_DEPTH_W);
    end
    if (DATA_W < 1) begin : g_bad_width
        $error("ladybird_level_fifo: DATA_W must be at least 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("ladybird_level_fifo: AF_LEVEL=%0d outside 1..%0d", AF_LEVEL, DEPTH);
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
        $error("ladybird_level_fifo: AE_LEVEL=%0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
    end

    logic [FIFO_DEPTH_W-1:0] wr_ptr;
    logic [FIFO_DEPTH_W-1:0] rd_ptr;
    logic                    full;
    logic                    wr_fire;
    logic                    rd_fire;
    logic                    drop_req;
    fifo_op_t                op;

    logic [DATA_W-1:0] mem [DEPTH];

    assign b_valid = (count != '0);
    assign rd_fire = b_valid & b_ready;
    // Gated on the registered full only, so a read in the same cycle never frees a slot early.
    assign wr_fire = a_valid & ~full;
    assign op      = fifo_op_t'({wr_fire, rd_fire});

    if (DROP_MODE != 0) begin : g_drop
        assign a_ready  = 1'b1;
        assign drop_req = a_valid & full & ~flush;
    end else begin : g_lossless
        assign a_ready  = ~full;
        assign drop_req = 1'b0;
    end

    ladybird_fifo_ctrl #(
        .FIFO_DEPTH_W (FIFO_DEPTH_W),
        .AF_LEVEL     (AF_LEVEL),
        .AE_LEVEL     (AE_LEVEL)
    ) u_ctrl (
        .clk          (clk),
        .nrst         (nrst),
        .op           (op),
        .flush        (flush),
        .drop_req     (drop_req),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .drop_cnt     (drop_cnt)
    );

    // Storage is intentionally left unreset; stale entries are hidden by b_valid.
    always_ff @(posedge clk) begin
        if (wr_fire && !flush) begin
            mem[wr_ptr] <= a_data;
        end
    end

    assign b_data = b_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_ladybird_level_fifo.sv
// Self-checking bench: hand-computed vector table, directed corner sequences and
// randomized traffic against a queue-based reference model, for both drop modes.
module tb_ladybird_level_fifo;

    localparam int DEPTH = 32;
    localparam int AF    = 28;
    localparam int AE    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst         [2];
    logic [7:0]  a_data       [2];
    logic        a_valid      [2];
    logic        a_ready      [2];
    logic [7:0]  b_data       [2];
    logic        b_valid      [2];
    logic        b_ready      [2];
    logic        flush        [2];
    logic [5:0]  count        [2];
    logic        almost_full  [2];
    logic        almost_empty [2];
    logic [15:0] drop_cnt     [2];

    // Instance 0 is lossless, instance 1 drops and counts writes while full.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ladybird_level_fifo #(
            .FIFO_DEPTH_W (5),
            .DATA_W       (8),
            .AF_LEVEL     (AF),
            .AE_LEVEL     (AE),
            .DROP_MODE    (gi)
        ) u_dut (
            .clk          (clk),
            .nrst         (nrst[gi]),
            .a_data       (a_data[gi]),
            .a_valid      (a_valid[gi]),
            .a_ready      (a_ready[gi]),
            .b_data       (b_data[gi]),
            .b_valid      (b_valid[gi]),
            .b_ready      (b_ready[gi]),
            .flush        (flush[gi]),
            .count        (count[gi]),
            .almost_full  (almost_full[gi]),
            .almost_empty (almost_empty[gi]),
            .drop_cnt     (drop_cnt[gi])
        );
    end

    int errors = 0;
    int checks = 0;
    int cur    = 0;

    // Reference model: contents as a queue plus the drop tally.
    logic [7:0]  mq [$];
    int unsigned mdrop = 0;

    typedef struct {
        logic       av;
        logic [7:0] ad;
        logic       br;
        logic       fl;
        int         ecnt;
        logic       ebv;
        logic [7:0] ebd;
        logic       eae;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0h, expected %0h (t=%0t)", cur, name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = mq.size();
        chk("count", 32'(count[cur]), 32'(sz));
        chk("b_valid", 32'(b_valid[cur]), 32'(sz != 0));
        chk("b_data", 32'(b_data[cur]), (sz != 0) ? 32'(mq[0]) : 32'd0);
        chk("a_ready", 32'(a_ready[cur]), 32'((cur == 1) || (sz != DEPTH)));
        chk("almost_full", 32'(almost_full[cur]), 32'(sz >= AF));
        chk("almost_empty", 32'(almost_empty[cur]), 32'(sz <= AE));
        chk("drop_cnt", 32'(drop_cnt[cur]), mdrop);
    endtask

    task automatic model_update(input logic av, input logic [7:0] ad, input logic br, input logic fl);
        int sz;
        sz = mq.size();
        if (fl) begin
            mq.delete();
        end else begin
            if (sz > 0 && br) void'(mq.pop_front());
            if (av && sz < DEPTH) mq.push_back(ad);
            if (cur == 1 && av && sz == DEPTH && mdrop != 32'hFFFF) mdrop++;
        end
    endtask

    task automatic step_o(input logic av, input logic [7:0] ad, input logic br, input logic fl,
                          output int o_cnt, output logic o_bv, output logic [7:0] o_bd,
                          output logic o_ae);
        a_valid[cur] = av;
        a_data[cur]  = ad;
        b_ready[cur] = br;
        flush[cur]   = fl;
        @(negedge clk);
        check_outputs();
        o_cnt = int'(count[cur]);
        o_bv  = b_valid[cur];
        o_bd  = b_data[cur];
        o_ae  = almost_empty[cur];
        @(posedge clk);
        model_update(av, ad, br, fl);
        #1;
    endtask

    task automatic step(input logic av, input logic [7:0] ad, input logic br, input logic fl);
        int         c;
        logic       v;
        logic [7:0] d;
        logic       e;
        step_o(av, ad, br, fl, c, v, d, e);
    endtask

    task automatic idle_inputs(input int d);
        a_valid[d] = 1'b0;
        a_data[d]  = 8'h00;
        b_ready[d] = 1'b0;
        flush[d]   = 1'b0;
    endtask

    initial begin
        int         c;
        logic       v;
        logic [7:0] d;
        logic       e;

        // inputs: av ad br fl | expected seen in that cycle: count b_valid b_data almost_empty
        tbl[0]  = '{1'b1, 8'h05, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h05, 1'b1};
        tbl[2]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1};
        tbl[3]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1, 1'b1, 8'hA1, 1'b1};
        tbl[4]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 2, 1'b1, 8'hA1, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'hA2, 1'b1};
        tbl[6]  = '{1'b1, 8'hA4, 1'b1, 1'b1, 1, 1'b1, 8'hA3, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1};
        tbl[8]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'h5A, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h5A, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1};

        for (int i = 0; i < 2; i++) begin
            nrst[i] = 1'b0;
            idle_inputs(i);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst[0] = 1'b1;
        nrst[1] = 1'b1;
        @(posedge clk);
        #1;

        // Reset state of the lossless instance
        cur = 0;
        check_outputs();

        // Hand-computed vectors: FWFT latency, W&R, flush, single-entry read
        for (int i = 0; i < 12; i++) begin
            step_o(tbl[i].av, tbl[i].ad, tbl[i].br, tbl[i].fl, c, v, d, e);
            $display("vec %0d: count=%0d b_valid=%0b b_data=%02h almost_empty=%0b", i, c, v, d, e);
            chk($sformatf("vec%0d_count", i), 32'(c), 32'(tbl[i].ecnt));
            chk($sformatf("vec%0d_b_valid", i), 32'(v), 32'(tbl[i].ebv));
            chk($sformatf("vec%0d_b_data", i), 32'(d), 32'(tbl[i].ebd));
            chk($sformatf("vec%0d_almost_empty", i), 32'(e), 32'(tbl[i].eae));
        end

        // Fill to full with 0..31
        for (int i = 0; i < 32; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_count", 32'(count[0]), 32'd32);
        chk("fill_a_ready", 32'(a_ready[0]), 32'd0);
        chk("fill_almost_full", 32'(almost_full[0]), 32'd1);
        $display("fill: count=%0d a_ready=%0b", count[0], a_ready[0]);

        // Full with simultaneous write and read: only the read happens
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("full_wr_count", 32'(count[0]), 32'd31);
        chk("full_wr_a_ready", 32'(a_ready[0]), 32'd1);
        $display("full w&r: count=%0d a_ready=%0b", count[0], a_ready[0]);
        step(1'b1, 8'hEF, 1'b0, 1'b0);

        // Drain in order
        for (int i = 0; i < 32; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_b_valid", 32'(b_valid[0]), 32'd0);
        $display("drain: count=%0d b_valid=%0b", count[0], b_valid[0]);

        // Steady W&R at level 10 with pointer wrap
        for (int i = 0; i < 10; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 8'(i + 100), 1'b1, 1'b0);
        chk("steady_count", 32'(count[0]), 32'd10);
        $display("steady: count=%0d head=%02h", count[0], b_data[0]);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush at level 17 while writing
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i + 60), 1'b0, 1'b0);
        step(1'b1, 8'hAB, 1'b1, 1'b1);
        chk("flush_count", 32'(count[0]), 32'd0);
        chk("flush_b_valid", 32'(b_valid[0]), 32'd0);
        chk("flush_almost_empty", 32'(almost_empty[0]), 32'd1);
        $display("flush: count=%0d b_valid=%0b", count[0], b_valid[0]);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic, alternating write-heavy and read-heavy phases
        for (int i = 0; i < 800; i++) begin
            int ph;
            ph = (i / 100) % 2;
            step(1'($urandom_range(99) < (ph == 1 ? 40 : 85)), 8'($urandom),
                 1'($urandom_range(99) < (ph == 1 ? 85 : 35)), 1'($urandom_range(99) == 0));
        end
        $display("random mode0 done: count=%0d", count[0]);
        idle_inputs(0);

        // Drop-counting instance
        cur = 1;
        nrst[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst[1] = 1'b1;
        mq.delete();
        mdrop = 0;
        @(posedge clk);
        #1;
        check_outputs();

        for (int i = 0; i < 32; i++) step(1'b1, 8'(i + 32), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hD0, 1'b0, 1'b0);
        chk("drop_cnt3", 32'(drop_cnt[1]), 32'd3);
        chk("drop_count", 32'(count[1]), 32'd32);
        chk("drop_head", 32'(b_data[1]), 32'd32);
        $display("drop: drop_cnt=%0d count=%0d", drop_cnt[1], count[1]);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(99) < 80), 8'($urandom),
                 1'($urandom_range(99) < 40), 1'($urandom_range(99) == 0));
        end
        for (int i = 0; i < 35; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        $display("random mode1 done: count=%0d drop_cnt=%0d", count[1], drop_cnt[1]);

        // Asynchronous reset in the middle of a write burst
        a_valid[1] = 1'b1;
        a_data[1]  = 8'h77;
        b_ready[1] = 1'b1;
        #2;
        nrst[1] = 1'b0;
        #1;
        chk("arst_count", 32'(count[1]), 32'd0);
        chk("arst_b_valid", 32'(b_valid[1]), 32'd0);
        chk("arst_b_data", 32'(b_data[1]), 32'd0);
        chk("arst_a_ready", 32'(a_ready[1]), 32'd1);
        chk("arst_almost_full", 32'(almost_full[1]), 32'd0);
        chk("arst_almost_empty", 32'(almost_empty[1]), 32'd1);
        chk("arst_drop_cnt", 32'(drop_cnt[1]), 32'd0);
        $display("async reset: count=%0d drop_cnt=%0d", count[1], drop_cnt[1]);
        idle_inputs(1);
        @(negedge clk);
        nrst[1] = 1'b1;
        mq.delete();
        mdrop = 0;
        @(posedge clk);
        #1;
        step(1'b1, 8'h42, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
